// File: rtl/seven_seg_reader.sv
// -----------------------------------------------------------------------------
// seven_seg_reader
//
// Watches a multiplexed seven-segment display bus and recovers the hex digit
// shown on each position. It undoes the 4-bit-to-segment encoding used by the
// display driver, so the reaction-timer datapath can read back what it shows.
//
// A bus state ({anodes, segments}) has to be seen unchanged for STABLE_CYCLES
// consecutive samples before it is decoded. Only one capture is made per
// stable window. Recognised patterns are written into a per-digit register
// file and marked valid. Patterns that are not in the code table clear the
// valid flag for that slot and are reported as invalid.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digit positions (1-8)
//   STABLE_CYCLES  identical samples required before capture (2-255)
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   anodes           digit enables, active-low (bit i low selects digit i)
//   segments         segment lines {a,b,c,d,e,f,g}, active-high, a is MSB
//   digits_out       recovered nibbles, digit i at [4i+3:4i]
//   digit_valid      bit i set when slot i holds a decoded value
//   update           one-cycle pulse when a slot is written with a valid code
//   update_idx       slot index for update / invalid_pattern
//   invalid_pattern  one-cycle pulse when a stable pattern is not a known code
//   err_count        saturating count of invalid patterns (only when the
//                    macro SEVEN_SEG_READER_ERRCNT_EN is defined)
// -----------------------------------------------------------------------------
module seven_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   anodes,
    input  logic [6:0]              segments,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    invalid_pattern
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    typedef enum logic [1:0] {
        SETTLE,
        CHECK,
        HOLD
    } state_t;

    localparam int SAMPLE_W = NUM_DIGITS + 7;

    // The counter value after a full window's worth of matching samples,
    // minus one: the FSM arms CHECK one cycle early. That lets the decoded
    // result register on the edge that completes the window.
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_RESET = {{NUM_DIGITS{1'b1}}, 7'h00};

    state_t                state;
    logic [SAMPLE_W-1:0]   sample_q;
    logic [SAMPLE_W-1:0]   bus_now;
    logic                  changed;
    logic [7:0]            stab_cnt;

    logic [NUM_DIGITS-1:0] sample_anodes;
    logic [6:0]            sample_segs;

    logic                  code_ok;
    logic [3:0]            nibble;

    logic [3:0]            sel_count;
    logic [2:0]            sel_idx;
    logic                  sel_one;

    assign bus_now       = {anodes, segments};
    assign changed       = (bus_now != sample_q);
    assign sample_anodes = sample_q[SAMPLE_W-1:7];
    assign sample_segs   = sample_q[6:0];

    // Inverse of the display driver's segment encoding. The all-off pattern
    // maps to 0 on purpose, so a blanked digit reads back as zero.
    always_comb begin
        code_ok = 1'b1;
        nibble  = 4'h0;
        case (sample_segs)
            7'h00:   nibble = 4'h0;
            7'h30:   nibble = 4'h1;
            7'h6D:   nibble = 4'h2;
            7'h79:   nibble = 4'h3;
            7'h33:   nibble = 4'h4;
            7'h5B:   nibble = 4'h5;
            7'h5F:   nibble = 4'h6;
            7'h70:   nibble = 4'h7;
            7'h7F:   nibble = 4'h8;
            7'h7B:   nibble = 4'h9;
            7'h77:   nibble = 4'hA;
            7'h1F:   nibble = 4'hB;
            7'h4E:   nibble = 4'hC;
            7'h3D:   nibble = 4'hD;
            7'h4F:   nibble = 4'hE;
            7'h47:   nibble = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    // Count the active-low anodes and remember the last active index. The
    // bus state is decoded only when exactly one digit is selected.
    always_comb begin
        sel_count = 4'd0;
        sel_idx   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sample_anodes[i]) begin
                sel_count = sel_count + 4'd1;
                sel_idx   = 3'(i);
            end
        end
        sel_one = (sel_count == 4'd1);
    end

    // Sampling, stability counting, FSM and the registered decode outputs.
    // Any change on the bus clears the counter and sends the FSM back to
    // SETTLE. CHECK lasts one cycle and makes the single capture for the
    // window. HOLD then waits for the bus to move again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= SETTLE;
            sample_q        <= SAMPLE_RESET;
            stab_cnt        <= 8'd0;
            digits_out      <= '0;
            digit_valid     <= '0;
            update          <= 1'b0;
            update_idx      <= 3'd0;
            invalid_pattern <= 1'b0;
`ifdef SEVEN_SEG_READER_ERRCNT_EN
            err_count       <= 8'd0;
`endif
        end else begin
            sample_q        <= bus_now;
            update          <= 1'b0;
            invalid_pattern <= 1'b0;

            if (changed) begin
                stab_cnt <= 8'd0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            case (state)
                SETTLE: begin
                    if (!changed && stab_cnt == CNT_ARM) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (sel_one) begin
                        update_idx <= sel_idx;
                        if (code_ok) begin
                            update <= 1'b1;
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (sel_idx == 3'(i)) begin
                                    digits_out[4*i +: 4] <= nibble;
                                    digit_valid[i]       <= 1'b1;
                                end
                            end
                        end else begin
                            invalid_pattern <= 1'b1;
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (sel_idx == 3'(i)) begin
                                    digit_valid[i] <= 1'b0;
                                end
                            end
`ifdef SEVEN_SEG_READER_ERRCNT_EN
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
`endif
                        end
                    end
                    state <= changed ? SETTLE : HOLD;
                end
                HOLD: begin
                    if (changed) begin
                        state <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_reader
//
// Self-checking bench for seven_seg_reader with NUM_DIGITS = 4 and
// STABLE_CYCLES = 8. A table of display states drives the DUT. Each entry
// gives the expected pulse and the nibble to be captured. Hand-written
// sequences cover capture latency, glitch and toggle rejection, and reset in
// the middle of a stable window. err_count is checked when
// SEVEN_SEG_READER_ERRCNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seven_seg_reader;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int NV = 22;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [ND-1:0] anodes;
    logic [6:0]    segments;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0] digit_valid;
    logic          update;
    logic [2:0]    update_idx;
    logic          invalid_pattern;
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    always #5 clk = ~clk;

    seven_seg_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .anodes          (anodes),
        .segments        (segments),
        .digits_out      (digits_out),
        .digit_valid     (digit_valid),
        .update          (update),
        .update_idx      (update_idx),
        .invalid_pattern (invalid_pattern)
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        bit         exp_upd;
        bit         exp_inv;
        logic [2:0] idx;
        logic [3:0] nib;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    int         upd_seen  = 0;
    int         inv_seen  = 0;
    int         both_seen = 0;
    logic [2:0] last_idx  = 3'd0;

    always @(negedge clk) begin
        if (update) begin
            upd_seen++;
            last_idx = update_idx;
        end
        if (invalid_pattern) begin
            inv_seen++;
            last_idx = update_idx;
        end
        if (update && invalid_pattern) begin
            both_seen++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg);
        anodes   = an;
        segments = seg;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t       vecs [NV];
    logic [6:0] codes [16];
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    int          exp_err;
    int          u0;
    int          i0;
    int          early;

    initial begin
        codes = '{7'h00, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{4'b1011, codes[k], 1'b1, 1'b0, 3'd2, 4'(k)};
        end
        vecs[16] = '{4'b0111, 7'h30, 1'b1, 1'b0, 3'd3, 4'h1};
        vecs[17] = '{4'b0111, 7'h01, 1'b0, 1'b1, 3'd3, 4'h0};
        vecs[18] = '{4'b1111, 7'h7F, 1'b0, 1'b0, 3'd0, 4'h0};
        vecs[19] = '{4'b1100, 7'h7F, 1'b0, 1'b0, 3'd0, 4'h0};
        vecs[20] = '{4'b1101, 7'h7E, 1'b0, 1'b1, 3'd1, 4'h0};
        vecs[21] = '{4'b1110, 7'h4F, 1'b1, 1'b0, 3'd0, 4'hE};

        exp_digits = 16'h0000;
        exp_valid  = 4'b0000;
        exp_err    = 0;

        // Reset state.
        reset_n = 1'b0;
        applyStimulus(4'b1111, 7'h00);
        step(3);
        checkOutput("reset digits_out", 32'(digits_out), 32'h0);
        checkOutput("reset digit_valid", 32'(digit_valid), 32'h0);
        checkOutput("reset update", 32'(update), 32'h0);
        checkOutput("reset invalid_pattern", 32'(invalid_pattern), 32'h0);
        checkOutput("reset update_idx", 32'(update_idx), 32'h0);
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        checkOutput("reset err_count", 32'(err_count), 32'h0);
`endif

        // Capture latency: change before edge E, pulse after edge E+8.
        reset_n = 1'b1;
        applyStimulus(4'b1110, 7'h5B);
        early = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            if (k < 9 && (update || invalid_pattern)) early++;
            if (k == 9) begin
                checkOutput("t1 update at edge 9", 32'(update), 32'h1);
                checkOutput("t1 update_idx", 32'(update_idx), 32'h0);
                checkOutput("t1 digits_out", 32'(digits_out), 32'h0005);
                checkOutput("t1 digit_valid", 32'(digit_valid), 32'h1);
            end
        end
        checkOutput("t1 early pulses", 32'(early), 32'h0);
        step(11);
        checkOutput("t1 total updates", 32'(upd_seen), 32'h1);
        exp_digits[3:0] = 4'h5;
        exp_valid[0]    = 1'b1;

        // One-cycle glitch, then the same value again: exactly one recapture.
        u0 = upd_seen;
        i0 = inv_seen;
        applyStimulus(4'b1110, 7'h6D);
        step(1);
        applyStimulus(4'b1110, 7'h5B);
        step(12);
        checkOutput("glitch update count", 32'(upd_seen - u0), 32'h1);
        checkOutput("glitch invalid count", 32'(inv_seen - i0), 32'h0);
        checkOutput("glitch last idx", 32'(last_idx), 32'h0);
        checkOutput("glitch digits_out", 32'(digits_out), 32'(exp_digits));

        // Toggle every 5 cycles on digit 1: the window never completes.
        u0 = upd_seen;
        i0 = inv_seen;
        for (int t = 0; t < 8; t++) begin
            applyStimulus(4'b1101, (t % 2 == 1) ? 7'h33 : 7'h79);
            step(5);
        end
        checkOutput("toggle update count", 32'(upd_seen - u0), 32'h0);
        checkOutput("toggle invalid count", 32'(inv_seen - i0), 32'h0);
        checkOutput("toggle digit_valid", 32'(digit_valid), 32'(exp_valid));

        // Table-driven sweep.
        for (int v = 0; v < NV; v++) begin
            u0 = upd_seen;
            i0 = inv_seen;
            applyStimulus(vecs[v].an, vecs[v].seg);
            step(12);
            if (vecs[v].exp_upd) begin
                exp_digits[int'(vecs[v].idx)*4 +: 4] = vecs[v].nib;
                exp_valid[vecs[v].idx] = 1'b1;
            end
            if (vecs[v].exp_inv) begin
                exp_valid[vecs[v].idx] = 1'b0;
                exp_err++;
            end
            checkOutput($sformatf("vec%0d update count", v), 32'(upd_seen - u0), 32'(vecs[v].exp_upd));
            checkOutput($sformatf("vec%0d invalid count", v), 32'(inv_seen - i0), 32'(vecs[v].exp_inv));
            if (vecs[v].exp_upd || vecs[v].exp_inv) begin
                checkOutput($sformatf("vec%0d update_idx", v), 32'(last_idx), 32'(vecs[v].idx));
            end
            checkOutput($sformatf("vec%0d digits_out", v), 32'(digits_out), 32'(exp_digits));
            checkOutput($sformatf("vec%0d digit_valid", v), 32'(digit_valid), 32'(exp_valid));
        end
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        checkOutput("err_count after sweep", 32'(err_count), 32'(exp_err));
`endif

        // Reset at cycle 5 of a stable window on digit 0.
        u0 = upd_seen;
        i0 = inv_seen;
        applyStimulus(4'b1110, 7'h5B);
        step(5);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset digits_out", 32'(digits_out), 32'h0);
        checkOutput("midreset digit_valid", 32'(digit_valid), 32'h0);
        checkOutput("midreset update_idx", 32'(update_idx), 32'h0);
`ifdef SEVEN_SEG_READER_ERRCNT_EN
        checkOutput("midreset err_count", 32'(err_count), 32'h0);
`endif
        step(2);
        checkOutput("midreset update count", 32'(upd_seen - u0), 32'h0);
        checkOutput("midreset invalid count", 32'(inv_seen - i0), 32'h0);

        // After release a full new window is required.
        reset_n = 1'b1;
        early = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            if (k < 9 && (update || invalid_pattern)) early++;
            if (k == 9) begin
                checkOutput("post-reset update at edge 9", 32'(update), 32'h1);
                checkOutput("post-reset digits_out", 32'(digits_out), 32'h0005);
                checkOutput("post-reset digit_valid", 32'(digit_valid), 32'h1);
            end
        end
        checkOutput("post-reset early pulses", 32'(early), 32'h0);
        step(3);
        checkOutput("update/invalid overlap", 32'(both_seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
